// File: rtl/siso_frame_ctrl.sv
// siso_frame_ctrl: round-robin arbiter feeding one MSB-first serial shifter.
// A granted requester's word is captured into a shift register and clocked
// out one bit per cycle, followed by a done pulse and GAP idle cycles.
// Optional build macro: SISO_FRAME_PARITY_EN appends an even-parity bit
// (XOR of the captured word) as an extra frame bit after the LSB.
module siso_frame_ctrl #(
  parameter int N    = 8,
  parameter int NREQ = 4,
  parameter int GAP  = 1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NREQ-1:0]                            req,
  input  logic [NREQ*N-1:0]                          data_flat,
  output logic [NREQ-1:0]                            gnt,
  output logic [(NREQ > 1 ? $clog2(NREQ) : 1)-1:0]   owner,
  output logic                                       ser_out,
  output logic                                       ser_valid,
  output logic                                       busy,
  output logic                                       done
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef SISO_FRAME_PARITY_EN
  localparam int FLEN = N + 1;
`else
  localparam int FLEN = N;
`endif
  localparam int CW       = (FLEN > 1) ? $clog2(FLEN) : 1;
  localparam int GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GAP_INIT = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAPW  = 2'd2
  } state_t;

  state_t            r_state;
  logic [FLEN-1:0]   r_shift;
  logic [CW-1:0]     r_cnt;
  logic [GW-1:0]     r_gap;
  logic [OW-1:0]     r_last;
  logic [OW-1:0]     r_owner;
  logic [NREQ-1:0]   r_gnt;
  logic              r_ser_out;
  logic              r_ser_valid;
  logic              r_busy;
  logic              r_done;

  logic [N-1:0]      w_words [NREQ];
  logic [N-1:0]      w_word;
  logic [FLEN-1:0]   w_load;
  logic [OW-1:0]     w_sel;
  logic              w_found;

  // Unpack the flat data bus into one word per requester.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_words[gi] = data_flat[gi*N +: N];
  end

  assign w_word = w_words[w_sel];

  // Shift register load: MSB goes straight to ser_out, the rest waits here.
`ifdef SISO_FRAME_PARITY_EN
  logic w_par;
  assign w_par  = ^w_word;
  assign w_load = {w_word[N-2:0], w_par, 1'b0};
`else
  assign w_load = {w_word[N-2:0], 1'b0};
`endif

  // Rotating-priority search starting one past the last granted requester.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(r_last) + k) % NREQ;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_sel   = OW'(idx);
      end
    end
  end

  // Frame FSM: grant and capture, shift out, optional idle gap; outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_last      <= OW'(NREQ - 1);
      r_owner     <= '0;
      r_gnt       <= '0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_gnt  <= '0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state     <= S_SHIFT;
            r_shift     <= w_load;
            r_cnt       <= CW'(FLEN - 1);
            r_ser_out   <= w_word[N-1];
            r_ser_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_gnt       <= NREQ'(1) << w_sel;
            r_owner     <= w_sel;
            r_last      <= w_sel;
          end
        end
        S_SHIFT: begin
          if (r_cnt == '0) begin
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_done      <= 1'b1;
            if (GAP > 0) begin
              r_state <= S_GAPW;
              r_gap   <= GW'(GAP_INIT);
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_ser_out <= r_shift[FLEN-1];
            r_shift   <= {r_shift[FLEN-2:0], 1'b0};
            r_cnt     <= r_cnt - 1'b1;
          end
        end
        S_GAPW: begin
          if (r_gap == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign owner     = r_owner;
  assign ser_out   = r_ser_out;
  assign ser_valid = r_ser_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_siso_frame_ctrl.sv
// Testbench for siso_frame_ctrl: random and directed request patterns checked
// every cycle against a frame-timeline reference model.
module tb_siso_frame_ctrl;

  localparam int N    = 8;
  localparam int NREQ = 4;
  localparam int GAP  = 1;
  localparam int OW   = $clog2(NREQ);
`ifdef SISO_FRAME_PARITY_EN
  localparam int FLEN = N + 1;
`else
  localparam int FLEN = N;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*N-1:0]    data_flat = '0;
  logic [NREQ-1:0]      gnt;
  logic [OW-1:0]        owner;
  logic                 ser_out;
  logic                 ser_valid;
  logic                 busy;
  logic                 done;

  siso_frame_ctrl #(.N(N), .NREQ(NREQ), .GAP(GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data_flat (data_flat),
    .gnt       (gnt),
    .owner     (owner),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: the last grant and how many cycles ago it became visible.
  bit           m_have  = 1'b0;
  int           m_off   = 0;
  logic [N-1:0] m_word  = '0;
  int           m_idx   = 0;
  int           m_last  = NREQ - 1;
  int           m_owner = 0;
  int           n_grants = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_idle();
    return !m_have || (m_off >= FLEN + GAP);
  endfunction

  // Frame bit at position off: word MSB first, then parity when enabled.
  function automatic logic frame_bit(input logic [N-1:0] w, input int off);
    if (off < N) return w[N-1-off];
    return ^w;
  endfunction

  task automatic check_cycle();
    logic [NREQ-1:0] e_gnt;
    logic            e_out, e_val, e_busy, e_done;
    e_gnt = '0; e_out = 1'b0; e_val = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    if (m_have) begin
      if (m_off == 0) e_gnt = NREQ'(1) << m_idx;
      if (m_off < FLEN) begin
        e_val = 1'b1;
        e_out = frame_bit(m_word, m_off);
      end
      e_done = (m_off == FLEN);
      e_busy = (m_off < FLEN + GAP);
    end
    chk("gnt",       32'(gnt),       32'(e_gnt));
    chk("owner",     32'(owner),     32'(m_owner));
    chk("ser_out",   32'(ser_out),   32'(e_out));
    chk("ser_valid", 32'(ser_valid), 32'(e_val));
    chk("busy",      32'(busy),      32'(e_busy));
    chk("done",      32'(done),      32'(e_done));
  endtask

  initial begin
    bit did_rst;
    did_rst = 1'b0;
    for (int cyc = 0; cyc < 1700; cyc++) begin
      @(posedge clk);
      #1;
      check_cycle();

      // Choose inputs for this cycle (sampled at the next rising edge).
      reset = 1'b0;
      if (cyc < 3) begin
        reset = 1'b1;
        req   = '0;
      end else if (cyc < 200) begin
        req       = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
        data_flat = {$urandom, $urandom};
      end else if (cyc < 400) begin
        req       = '1;
        data_flat = {8'h88, 8'h44, 8'h22, 8'h11};
      end else if (cyc < 700) begin
        req       = 4'b0100;
        data_flat = {$urandom, $urandom};
      end else if (cyc < 1500) begin
        reset     = ($urandom_range(0, 49) == 0);
        req       = NREQ'($urandom);
        data_flat = {$urandom, $urandom};
      end else begin
        data_flat = {$urandom, $urandom};
        if (!did_rst) begin
          req = 4'b1000;
          if (m_have && m_idx == 3 && m_off == 3) begin
            reset   = 1'b1;
            req     = 4'b0011;
            did_rst = 1'b1;
          end
        end else begin
          req = 4'b0011;
        end
      end

      // Advance the model to the next cycle.
      if (reset) begin
        m_have  = 1'b0;
        m_owner = 0;
        m_last  = NREQ - 1;
      end else if (model_idle() && req != '0) begin
        for (int k = 1; k <= NREQ; k++) begin
          int i;
          i = (m_last + k) % NREQ;
          if (req[i]) begin
            m_idx = i;
            break;
          end
        end
        m_word  = data_flat[m_idx*N +: N];
        m_have  = 1'b1;
        m_off   = 0;
        m_last  = m_idx;
        m_owner = m_idx;
        n_grants++;
        $display("[TB] cycle %0d: grant req %0d word %h", cyc + 1, m_idx, m_word);
      end else if (m_have && m_off < 1000) begin
        m_off++;
      end
    end
    chk("grants_seen_min", 32'(n_grants > 100), 32'd1);
    chk("midframe_reset_done", 32'(did_rst), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
